sd_data_xfer_seq: RTL

Multi-block transfer sequencer sitting between the host register/command logic and `sd_data_master`. For one software request of N blocks it issues per-block start pulses, waits for each block's interrupt status, clears it, and inserts a programmable inter-block gap. It aggregates per-block errors into one sticky status word and optionally requests a stop command after multi-block transfers.

---
 rtl/sd_data_xfer_seq_if.sv | 33 +++
 rtl/sd_data_xfer_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sd_data_xfer_seq_if.sv
// Host-side request/status bundle and sd_data_master handshake for sd_data_xfer_seq.
// master = host/environment side, slave = the sequencer.
interface sd_data_xfer_seq_if #(
  parameter int BLKCNT_W      = 16,
  parameter int GAP_W         = 8,
  parameter int INT_DATA_SIZE = 5
);
  logic                     go_i;
  logic                     abort_i;
  logic                     dir_i;
  logic [BLKCNT_W-1:0]      blk_cnt_i;
  logic [GAP_W-1:0]         gap_i;
  logic                     start_tx_o;
  logic                     start_rx_o;
  logic [INT_DATA_SIZE-1:0] dm_int_status_i;
  logic                     dm_int_rst_o;
  logic                     stop_req_o;
  logic                     stop_ack_i;
  logic                     busy_o;
  logic [BLKCNT_W-1:0]      blk_done_o;
  logic [4:0]               int_status_o;
  logic                     int_status_rst_i;

  modport master (
    output go_i, abort_i, dir_i, blk_cnt_i, gap_i, dm_int_status_i, stop_ack_i, int_status_rst_i,
    input  start_tx_o, start_rx_o, dm_int_rst_o, stop_req_o, busy_o, blk_done_o, int_status_o
  );

  modport slave (
    input  go_i, abort_i, dir_i, blk_cnt_i, gap_i, dm_int_status_i, stop_ack_i, int_status_rst_i,
    output start_tx_o, start_rx_o, dm_int_rst_o, stop_req_o, busy_o, blk_done_o, int_status_o
  );
endinterface

// File: rtl/sd_data_xfer_seq.sv
// Multi-block transfer sequencer in front of sd_data_master: start pulses, status clear, gap, sticky errors.
// Optional stop-command request after multi-block jobs when SD_XFER_SEQ_AUTO_STOP_EN is defined.
module sd_data_xfer_seq #(
  parameter int BLKCNT_W = 16,
  parameter int GAP_W    = 8
) (
  input  logic              sd_clk,
  input  logic              rst,
  sd_data_xfer_seq_if.slave bus
);
  // sd_data_master data-interrupt bit positions
  localparam int INT_DATA_CC    = 0;
  localparam int INT_DATA_EI    = 1;
  localparam int INT_DATA_CTE   = 2;
  localparam int INT_DATA_CCRCE = 3;
  localparam int INT_DATA_CFE   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CLEAR,
    S_GAP,
    S_DONE
`ifdef SD_XFER_SEQ_AUTO_STOP_EN
    ,
    S_STOP
`endif
  } state_t;

  state_t              state_reg, state_next, end_state;
  logic                dir_reg, dir_next;
  logic [BLKCNT_W-1:0] cnt_reg, cnt_next;
  logic [BLKCNT_W-1:0] blk_done_reg, blk_done_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic                abort_reg, abort_next, abort_seen;
  // [0] error-terminated, [1] CRC, [2] FIFO, [3] timeout
  logic [3:0]          err_reg, err_next;
  logic [4:0]          int_status_reg, int_status_next;
  logic                start_tx, start_rx, dm_int_rst;

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      dir_reg        <= 1'b0;
      cnt_reg        <= '0;
      gap_reg        <= '0;
      gap_cnt_reg    <= '0;
      abort_reg      <= 1'b0;
      err_reg        <= '0;
      blk_done_reg   <= '0;
      int_status_reg <= '0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      cnt_reg        <= cnt_next;
      gap_reg        <= gap_next;
      gap_cnt_reg    <= gap_cnt_next;
      abort_reg      <= abort_next;
      err_reg        <= err_next;
      blk_done_reg   <= blk_done_next;
      int_status_reg <= int_status_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    dir_next        = dir_reg;
    cnt_next        = cnt_reg;
    gap_next        = gap_reg;
    gap_cnt_next    = gap_cnt_reg;
    abort_next      = abort_reg;
    err_next        = err_reg;
    blk_done_next   = blk_done_reg;
    int_status_next = int_status_reg;
    start_tx        = 1'b0;
    start_rx        = 1'b0;
    dm_int_rst      = 1'b0;
    abort_seen      = abort_reg | bus.abort_i;
    end_state       = S_DONE;
`ifdef SD_XFER_SEQ_AUTO_STOP_EN
    if (cnt_reg > BLKCNT_W'(1)) begin
      end_state = S_STOP;
    end
`endif

    if (state_reg != S_IDLE) begin
      abort_next = abort_seen;
    end
    if (bus.int_status_rst_i) begin
      int_status_next = '0;
    end

    case (state_reg)
      S_IDLE: begin
        if (bus.go_i) begin
          dir_next      = bus.dir_i;
          cnt_next      = bus.blk_cnt_i;
          gap_next      = bus.gap_i;
          blk_done_next = '0;
          abort_next    = 1'b0;
          err_next      = '0;
          state_next    = (bus.blk_cnt_i == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        // an abort latched in the gap (or arriving now) suppresses the pulse
        if (abort_seen) begin
          state_next = end_state;
        end else begin
          start_tx   = dir_reg;
          start_rx   = ~dir_reg;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.dm_int_status_i != '0) begin
          if (bus.dm_int_status_i[INT_DATA_EI]) begin
            err_next = err_reg | {bus.dm_int_status_i[INT_DATA_CTE],
                                  bus.dm_int_status_i[INT_DATA_CFE],
                                  bus.dm_int_status_i[INT_DATA_CCRCE], 1'b1};
          end else if (bus.dm_int_status_i[INT_DATA_CC]) begin
            blk_done_next = blk_done_reg + BLKCNT_W'(1);
          end
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        dm_int_rst = 1'b1;
        if (err_reg[0] || abort_seen || (blk_done_reg == cnt_reg)) begin
          state_next = end_state;
        end else if (gap_reg == '0) begin
          state_next = S_START;
        end else begin
          gap_cnt_next = gap_reg - GAP_W'(1);
          state_next   = S_GAP;
        end
      end
      S_GAP: begin
        if (abort_seen) begin
          state_next = end_state;
        end else if (gap_cnt_reg == '0) begin
          state_next = S_START;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
`ifdef SD_XFER_SEQ_AUTO_STOP_EN
      S_STOP: begin
        if (bus.stop_ack_i) begin
          state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        // the set takes priority over a simultaneous software clear
        int_status_next = int_status_reg | {abort_reg, err_reg[3:1], 1'b1};
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef SD_XFER_SEQ_AUTO_STOP_EN
  logic stop_req_reg;

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      stop_req_reg <= 1'b0;
    end else begin
      stop_req_reg <= (state_next == S_STOP) && (state_reg != S_STOP);
    end
  end

  assign bus.stop_req_o = stop_req_reg;
`else
  assign bus.stop_req_o = 1'b0;
`endif

  assign bus.start_tx_o   = start_tx;
  assign bus.start_rx_o   = start_rx;
  assign bus.dm_int_rst_o = dm_int_rst;
  assign bus.busy_o       = (state_reg != S_IDLE);
  assign bus.blk_done_o   = blk_done_reg;
  assign bus.int_status_o = int_status_reg;
endmodule
